// File: rtl/irq_pkg.sv
// Shared types and constants for the platform interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam logic [31:0] MCAUSE_IRQ_BASE = 32'h8000_0010;

  // Ceiling log2, used to confirm the id width can name every source.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: index 0 has the highest priority.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic [ID_W-1:0]    id_o,
  output logic               valid_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    id_o    = '0;
    valid_o = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        id_o    = ID_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Platform interrupt controller: edge/level capture, fixed-priority
// arbitration and a request/acknowledge/return handshake with the CSR unit.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no request outstanding; arbitrate when global_ie is set
// REQ     | interrupt raised, irq_id frozen, waiting for interrupt_taken
// SERVICE | trap handler running; no nesting, waiting for irq_done
module irq_controller
  import irq_pkg::*;
#(
  parameter int          NUM_SRC     = 8,
  parameter int          ID_W        = 3,
  parameter logic [31:0] MCAUSE_BASE = MCAUSE_IRQ_BASE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] irq_edge_sel,
  input  logic [NUM_SRC-1:0] irq_enable,
  input  logic               global_ie,
  input  logic               interrupt_taken,
  input  logic [31:0]        pc_address,
  input  logic               irq_done,
  output logic               interrupt,
  output logic [ID_W-1:0]    irq_id,
  output logic               in_service,
  output logic [31:0]        mepc,
  output logic [31:0]        mcause
);

  if (ID_W < clog2(NUM_SRC)) begin : g_id_w_check
    $error("irq_controller: ID_W too narrow for NUM_SRC");
  end

  irq_state_e         state_q;
  logic [NUM_SRC-1:0] irq_src_q;
  logic [NUM_SRC-1:0] edge_pend_q;
  logic [NUM_SRC-1:0] edge_pend_d;
  logic [NUM_SRC-1:0] edge_set;
  logic [NUM_SRC-1:0] edge_clr;
  logic [NUM_SRC-1:0] cand;
  logic [ID_W-1:0]    win_id;
  logic               win_valid;
  logic               ack;
  logic               interrupt_q;
  logic [ID_W-1:0]    irq_id_q;
  logic               in_service_q;
  logic [31:0]        mepc_q;
  logic [31:0]        mcause_q;

  assign ack = (state_q == REQ) && interrupt_taken;

  // Edge detect, clear-on-ack and set-wins merge for the pending register.
  always_comb begin
    edge_set    = irq_edge_sel & irq_src & ~irq_src_q;
    edge_clr    = ack ? (NUM_SRC'(1) << irq_id_q) : '0;
    edge_pend_d = (edge_pend_q & ~edge_clr) | edge_set;
    cand        = (edge_pend_q | (irq_src_q & ~irq_edge_sel)) & irq_enable;
  end

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .req_i   (cand),
    .id_o    (win_id),
    .valid_o (win_valid)
  );

  // Source sampler; loads during reset too so lines already high at release
  // do not look like fresh edges.
  always_ff @(posedge clk) begin
    irq_src_q <= irq_src;
  end

  // Pending edges; kept while a source is masked, cleared only on its ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_pend_q <= '0;
    end else begin
      edge_pend_q <= edge_pend_d;
    end
  end

  // Request/acknowledge/return sequencing with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      interrupt_q  <= 1'b0;
      irq_id_q     <= '0;
      in_service_q <= 1'b0;
      mepc_q       <= '0;
      mcause_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (global_ie && win_valid) begin
            irq_id_q    <= win_id;
            interrupt_q <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          // The request is never withdrawn; only the ack moves us on.
          if (interrupt_taken) begin
            interrupt_q  <= 1'b0;
            in_service_q <= 1'b1;
            mepc_q       <= pc_address;
            mcause_q     <= MCAUSE_BASE + 32'(irq_id_q);
            state_q      <= SERVICE;
          end
        end
        SERVICE: begin
          // A lingering registered ack here is expected and ignored.
          if (irq_done) begin
            in_service_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign interrupt  = interrupt_q;
  assign irq_id     = irq_id_q;
  assign in_service = in_service_q;
  assign mepc       = mepc_q;
  assign mcause     = mcause_q;

endmodule
